// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side packet reader.
//   DEF_WIDTH / DEF_PKT_LEN : default data width and beats per packet
//   STAT_W                  : width of the optional statistics counters
//   pkt_state_e             : packet FSM state, decoded from the beat counter
//   beat_cnt_w()            : beat-counter width for a given packet length
package fifo_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_PKT_LEN = 4;
    localparam int unsigned STAT_W      = 16;

    typedef enum logic {
        PktIdle,
        PktIn
    } pkt_state_e;

    // clog2(pkt_len), but never narrower than one bit so PKT_LEN=1 still builds.
    function automatic int unsigned beat_cnt_w(input int unsigned pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer that absorbs the FIFO read latency.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   push        : write push_data at the tail this edge
//   push_data   : data to append
//   pop         : drop the head this edge (only meaningful while count != 0)
//   head        : oldest entry, held stable until popped
//   count       : occupancy, 0..2
module fifo_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0_q;
    logic [WIDTH-1:0] mem1_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) mem0_q <= push_data;
                    else                 mem1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    mem0_q  <= mem1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new data goes behind whatever remains.
                    if (count_q == 2'd1) begin
                        mem0_q <= push_data;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = mem0_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side consumer of the async FIFO. Issues reads, lands the 1-cycle-late
// read data in a 2-entry skid buffer and presents a valid/ready stream with
// first/last flags on fixed-length packets.
// Optional feature: define FIFO_PKT_READER_STATS_EN to add pkt_count and
// stall_count (saturating, STAT_W bits).
// Ports:
//   rd_clk, reset       : read-domain clock, synchronous active-high reset
//   enable              : allow new FIFO reads
//   fifo_empty          : FIFO empty flag
//   fifo_rd_en          : FIFO read strobe
//   fifo_rd_data        : FIFO data, valid the cycle after fifo_rd_en
//   out_valid/out_ready : stream handshake
//   out_data            : stream beat
//   out_first/out_last  : packet boundary flags
//   pkt_count           : completed packets popped (stats build only)
//   stall_count         : cycles with out_valid && !out_ready (stats build only)
module fifo_pkt_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PKT_LEN = DEF_PKT_LEN
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
`ifdef FIFO_PKT_READER_STATS_EN
    output logic [STAT_W-1:0] pkt_count,
    output logic [STAT_W-1:0] stall_count,
`endif
    output logic              out_first,
    output logic              out_last
);

    localparam int unsigned      BeatW    = beat_cnt_w(PKT_LEN);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

    logic             inflight_q;
    logic [1:0]       skid_count;
    logic             pop;
    logic [2:0]       occ;
    logic [BeatW-1:0] beat_cnt_q;
    logic [BeatW-1:0] beat_cnt_d;
    pkt_state_e       pkt_state;

    assign out_valid = (skid_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Slots committed after this edge; a same-cycle pop frees one, which is
    // what keeps the stream at one beat per cycle.
    assign occ        = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = !reset && enable && !fifo_empty && (occ < 3'd2);

    always_ff @(posedge rd_clk) begin
        if (reset) inflight_q <= 1'b0;
        else       inflight_q <= fifo_rd_en;
    end

    fifo_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (rd_clk),
        .reset    (reset),
        .push     (inflight_q),
        .push_data(fifo_rd_data),
        .pop      (pop),
        .head     (out_data),
        .count    (skid_count)
    );

    // Packet FSM: state is implied by the beat counter.
    always_ff @(posedge rd_clk) begin
        if (reset) beat_cnt_q <= '0;
        else       beat_cnt_q <= beat_cnt_d;
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        pkt_state  = (beat_cnt_q == '0) ? PktIdle : PktIn;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LastBeat) ? '0 : beat_cnt_q + BeatW'(1);
        end
        out_first = out_valid && (pkt_state == PktIdle);
        out_last  = out_valid && (beat_cnt_q == LastBeat);
    end

`ifdef FIFO_PKT_READER_STATS_EN
    logic [STAT_W-1:0] pkt_count_q;
    logic [STAT_W-1:0] stall_count_q;

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (pop && out_last && (pkt_count_q != '1)) begin
                pkt_count_q <= pkt_count_q + STAT_W'(1);
            end
            if (out_valid && !out_ready && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + STAT_W'(1);
            end
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
